// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and constants for the IF/MEM memory port arbiter
//
// Contents:
//   arb_state_e  arbiter state (IDLE, GNT_DM, GNT_IF, RESP)
//   ABORT_DATA   read data returned when a transaction is aborted by the watchdog
//   CONFLICT_W   width of the saturating conflict counter
//   sat_inc      saturating increment for the conflict counter

package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_DM = 2'd1,
        GNT_IF = 2'd2,
        RESP   = 2'd3
    } arb_state_e;

    localparam logic [31:0] ABORT_DATA = 32'hDEAD_BEEF;

    localparam int CONFLICT_W = 16;

    // Holds at all-ones instead of wrapping back to zero.
    function automatic logic [CONFLICT_W-1:0] sat_inc(input logic [CONFLICT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// rtl/mem_port_arbiter_watchdog.sv - transaction watchdog counter for the memory port arbiter
//
// Ports:
//   clock    in   system clock
//   reset    in   asynchronous active-low reset
//   clear    in   return the count to zero (wins over enable)
//   enable   in   count one more waited cycle
//   expired  out  this is the TIMEOUT-th enabled cycle since the last clear

module arb_watchdog #(
    parameter int TIMEOUT = 255,
    parameter int TMO_W   = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // The count equals the number of enabled cycles already completed, so it
    // reads TIMEOUT-1 during the TIMEOUT-th waited cycle.
    localparam logic [TMO_W-1:0] LAST = TMO_W'(TIMEOUT - 1);

    logic [TMO_W-1:0] cnt_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired = enable & (cnt_q == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one backing memory port between IF fetch and MEM load/store
//
// Ports:
//   clock, reset                       system clock, asynchronous active-low reset
//   if_req/if_addr                     IF fetch request, held until if_done
//   if_rdata/if_done/if_stall          fetched word, completion pulse, IF stall
//   dm_req/dm_we/dm_addr/dm_wdata      MEM-stage load/store request, held until dm_done
//   dm_rdata/dm_done/dm_stall          load data, completion pulse, MEM stall
//   mem_req/mem_we/mem_addr/mem_wdata  registered backing-memory request
//   mem_ack/mem_rdata                  one-cycle acknowledge with read data
//   err_timeout                        sticky watchdog-abort flag
//   conflict_cnt                       saturating count of IDLE cycles with both requests pending

module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255,
    parameter int TMO_W   = 8,
    parameter logic [DATA_W-1:0] ABORT_DATA = mem_port_arbiter_pkg::ABORT_DATA
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic                                      if_req,
    input  logic [ADDR_W-1:0]                         if_addr,
    output logic [DATA_W-1:0]                         if_rdata,
    output logic                                      if_done,
    output logic                                      if_stall,
    input  logic                                      dm_req,
    input  logic                                      dm_we,
    input  logic [ADDR_W-1:0]                         dm_addr,
    input  logic [DATA_W-1:0]                         dm_wdata,
    output logic [DATA_W-1:0]                         dm_rdata,
    output logic                                      dm_done,
    output logic                                      dm_stall,
    output logic                                      mem_req,
    output logic                                      mem_we,
    output logic [ADDR_W-1:0]                         mem_addr,
    output logic [DATA_W-1:0]                         mem_wdata,
    input  logic                                      mem_ack,
    input  logic [DATA_W-1:0]                         mem_rdata,
    output logic                                      err_timeout,
    output logic [mem_port_arbiter_pkg::CONFLICT_W-1:0] conflict_cnt
);

    import mem_port_arbiter_pkg::*;

    arb_state_e state_q;
    arb_state_e state_d;

    logic                  grant_dm;
    logic                  grant_if;
    logic                  finish;
    logic                  abort;
    logic                  conflict;
    logic                  granted;
    logic                  wd_clear;
    logic                  wd_expired;
    logic [DATA_W-1:0]     resp_data;
    logic [CONFLICT_W-1:0] conflict_cnt_q;

    assign granted = (state_q == GNT_DM) || (state_q == GNT_IF);

    // Counter runs only while a transaction is outstanding and restarts from
    // zero for every grant.
    assign wd_clear = ~granted | finish | abort;

    arb_watchdog #(
        .TIMEOUT (TIMEOUT),
        .TMO_W   (TMO_W)
    ) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .clear   (wd_clear),
        .enable  (granted),
        .expired (wd_expired)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // An ack arriving in the expiry cycle is checked first, so a late but
    // valid response is never thrown away as a timeout.
    always_comb begin
        state_d  = state_q;
        grant_dm = 1'b0;
        grant_if = 1'b0;
        finish   = 1'b0;
        abort    = 1'b0;
        conflict = 1'b0;
        case (state_q)
            IDLE: begin
                conflict = dm_req & if_req;
                if (dm_req) begin
                    grant_dm = 1'b1;
                    state_d  = GNT_DM;
                end else if (if_req) begin
                    grant_if = 1'b1;
                    state_d  = GNT_IF;
                end
            end
            GNT_DM, GNT_IF: begin
                if (mem_ack) begin
                    finish  = 1'b1;
                    state_d = RESP;
                end else if (wd_expired) begin
                    abort   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                // Gap cycle: the requester still holds req while it sees done.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign resp_data = finish ? mem_rdata : ABORT_DATA;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            if_done        <= 1'b0;
            dm_done        <= 1'b0;
            if_rdata       <= '0;
            dm_rdata       <= '0;
            err_timeout    <= 1'b0;
            conflict_cnt_q <= '0;
        end else begin
            if_done <= 1'b0;
            dm_done <= 1'b0;

            if (conflict) begin
                conflict_cnt_q <= sat_inc(conflict_cnt_q);
            end

            if (grant_dm) begin
                mem_req   <= 1'b1;
                mem_we    <= dm_we;
                mem_addr  <= dm_addr;
                mem_wdata <= dm_wdata;
            end else if (grant_if) begin
                mem_req  <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= if_addr;
            end

            if (finish || abort) begin
                mem_req <= 1'b0;
                mem_we  <= 1'b0;
                if (state_q == GNT_DM) begin
                    dm_done <= 1'b1;
                    // Stores return no data; keep the last load result.
                    if (!mem_we) begin
                        dm_rdata <= resp_data;
                    end
                end else begin
                    if_done  <= 1'b1;
                    if_rdata <= resp_data;
                end
                if (abort) begin
                    err_timeout <= 1'b1;
                end
            end
        end
    end

    assign conflict_cnt = conflict_cnt_q;

    // Stalls depend on the live request so the pipeline freezes in the very
    // cycle it asks, and release exactly in the done cycle.
    assign if_stall = if_req & ~if_done;
    assign dm_stall = dm_req & ~dm_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter

module tb_mem_port_arbiter;

    localparam int TMO = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        if_stall;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic [31:0] dm_rdata;
    logic        dm_done;
    logic        dm_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        err_timeout;
    logic [15:0] conflict_cnt;

    int errors = 0;
    int checks = 0;
    bit preset_conf = 1'b0;

    mem_port_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (TMO),
        .TMO_W   (8)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_rdata     (if_rdata),
        .if_done      (if_done),
        .if_stall     (if_stall),
        .dm_req       (dm_req),
        .dm_we        (dm_we),
        .dm_addr      (dm_addr),
        .dm_wdata     (dm_wdata),
        .dm_rdata     (dm_rdata),
        .dm_done      (dm_done),
        .dm_stall     (dm_stall),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .err_timeout  (err_timeout),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the port, how many cycles it has waited, and
    // whether the one-cycle done gap is in progress.
    int          owner;   // 0 none, 1 data memory, 2 fetch
    int          waited;
    bit          gap;
    logic        m_mem_req, m_mem_we, m_if_done, m_dm_done, m_err;
    logic [31:0] m_mem_addr, m_mem_wdata, m_if_rdata, m_dm_rdata, m_data;
    logic [15:0] m_conf;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            owner = 0; waited = 0; gap = 0;
            m_mem_req = 0; m_mem_we = 0; m_mem_addr = 0; m_mem_wdata = 0;
            m_if_done = 0; m_dm_done = 0; m_if_rdata = 0; m_dm_rdata = 0;
            m_err = 0; m_conf = 0;
        end else begin
            if (preset_conf) m_conf = 16'hFFFE;
            m_if_done = 0;
            m_dm_done = 0;
            if (gap) begin
                gap = 0;
            end else if (owner == 0) begin
                if (dm_req && if_req && m_conf != 16'hFFFF) m_conf = m_conf + 16'd1;
                if (dm_req) begin
                    owner = 1; waited = 0;
                    m_mem_req = 1; m_mem_we = dm_we; m_mem_addr = dm_addr; m_mem_wdata = dm_wdata;
                end else if (if_req) begin
                    owner = 2; waited = 0;
                    m_mem_req = 1; m_mem_we = 0; m_mem_addr = if_addr;
                end
            end else begin
                waited = waited + 1;
                if (mem_ack || waited == TMO) begin
                    m_data = mem_ack ? mem_rdata : 32'hDEAD_BEEF;
                    if (owner == 1) begin
                        m_dm_done = 1;
                        if (!m_mem_we) m_dm_rdata = m_data;
                    end else begin
                        m_if_done = 1;
                        m_if_rdata = m_data;
                    end
                    if (!mem_ack) m_err = 1;
                    m_mem_req = 0; m_mem_we = 0;
                    owner = 0; gap = 1;
                end
            end
        end
    end

    always begin
        @(posedge clock);
        #2;
        if (reset) begin
            chk("cyc_mem_req",   {31'd0, mem_req},     {31'd0, m_mem_req});
            chk("cyc_mem_we",    {31'd0, mem_we},      {31'd0, m_mem_we});
            chk("cyc_mem_addr",  mem_addr,             m_mem_addr);
            chk("cyc_mem_wdata", mem_wdata,            m_mem_wdata);
            chk("cyc_if_done",   {31'd0, if_done},     {31'd0, m_if_done});
            chk("cyc_dm_done",   {31'd0, dm_done},     {31'd0, m_dm_done});
            chk("cyc_if_rdata",  if_rdata,             m_if_rdata);
            chk("cyc_dm_rdata",  dm_rdata,             m_dm_rdata);
            chk("cyc_err",       {31'd0, err_timeout}, {31'd0, m_err});
            chk("cyc_conflict",  {16'd0, conflict_cnt}, {16'd0, m_conf});
            chk("cyc_if_stall",  {31'd0, if_stall},    {31'd0, if_req & ~m_if_done});
            chk("cyc_dm_stall",  {31'd0, dm_stall},    {31'd0, dm_req & ~m_dm_done});
        end
    end

    task automatic step();
        @(negedge clock);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        step();
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_conflict", {16'd0, conflict_cnt}, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        step();
        reset = 1'b1;
        step();

        // IF-only fetch, ack one cycle after mem_req
        if_req = 1; if_addr = 32'h0000_0040; #1;
        chk("t1_stall_c0", {31'd0, if_stall}, 32'd1);
        step();
        chk("t1_mem_req_c1", {31'd0, mem_req}, 32'd1);
        chk("t1_mem_addr", mem_addr, 32'h0000_0040);
        chk("t1_stall_c1", {31'd0, if_stall}, 32'd1);
        step();
        chk("t1_stall_c2", {31'd0, if_stall}, 32'd1);
        chk("t1_done_c2", {31'd0, if_done}, 32'd0);
        mem_ack = 1; mem_rdata = 32'h2008_0005;
        step();
        chk("t1_done_c3", {31'd0, if_done}, 32'd1);
        chk("t1_rdata", if_rdata, 32'h2008_0005);
        chk("t1_stall_c3", {31'd0, if_stall}, 32'd0);
        mem_ack = 0; mem_rdata = 0;
        step();
        chk("t1_no_regrant", {31'd0, mem_req}, 32'd0);
        if_req = 0;
        step(); step();

        // Simultaneous store and fetch
        if_req = 1; if_addr = 32'h0000_0044;
        dm_req = 1; dm_we = 1; dm_addr = 32'h10; dm_wdata = 32'hCAFE_0001;
        step();
        chk("t2_store_we", {31'd0, mem_we}, 32'd1);
        chk("t2_store_addr", mem_addr, 32'h10);
        chk("t2_store_wdata", mem_wdata, 32'hCAFE_0001);
        chk("t2_conflict", {16'd0, conflict_cnt}, 32'd1);
        mem_ack = 1;
        step();
        chk("t2_dm_done", {31'd0, dm_done}, 32'd1);
        chk("t2_dm_rdata_kept", dm_rdata, 32'd0);
        chk("t2_if_still_stalled", {31'd0, if_stall}, 32'd1);
        mem_ack = 0;
        step();
        chk("t2_idle_gap", {31'd0, mem_req}, 32'd0);
        dm_req = 0; dm_we = 0;
        step();
        chk("t2_fetch_req", {31'd0, mem_req}, 32'd1);
        chk("t2_fetch_addr", mem_addr, 32'h0000_0044);
        chk("t2_conflict_hold", {16'd0, conflict_cnt}, 32'd1);
        mem_ack = 1; mem_rdata = 32'h1111_2222;
        step();
        chk("t2_if_rdata", if_rdata, 32'h1111_2222);
        mem_ack = 0;
        step();
        if_req = 0;
        step();

        // Load, zero-wait ack, stray ack in IDLE and RESP
        dm_req = 1; dm_we = 0; dm_addr = 32'h20; mem_ack = 1; mem_rdata = 32'hABCD_1234;
        step();
        chk("t3_mem_req_c1", {31'd0, mem_req}, 32'd1);
        step();
        chk("t3_dm_done_c2", {31'd0, dm_done}, 32'd1);
        chk("t3_dm_rdata", dm_rdata, 32'hABCD_1234);
        chk("t3_mem_req_c2", {31'd0, mem_req}, 32'd0);
        mem_rdata = 32'h5555_5555;
        step();
        chk("t3_no_regrant", {31'd0, mem_req}, 32'd0);
        chk("t3_rdata_kept", dm_rdata, 32'hABCD_1234);
        dm_req = 0; mem_ack = 0;
        step(); step();

        // Fetch whose ack lands in the expiry cycle: ack wins
        if_req = 1; if_addr = 32'h80;
        step(); step(); step();
        chk("t4_still_waiting", {31'd0, mem_req}, 32'd1);
        step();
        mem_ack = 1; mem_rdata = 32'h7777_8888;
        step();
        chk("t4_if_done", {31'd0, if_done}, 32'd1);
        chk("t4_if_rdata", if_rdata, 32'h7777_8888);
        chk("t4_no_err", {31'd0, err_timeout}, 32'd0);
        mem_ack = 0;
        step();
        if_req = 0;
        step();

        // Load with no ack: abort after TMO grant cycles
        dm_req = 1; dm_we = 0; dm_addr = 32'h30;
        step(); step(); step(); step();
        chk("t5_grant_c4", {31'd0, mem_req}, 32'd1);
        chk("t5_done_c4", {31'd0, dm_done}, 32'd0);
        step();
        chk("t5_done_c5", {31'd0, dm_done}, 32'd1);
        chk("t5_abort_data", dm_rdata, 32'hDEAD_BEEF);
        chk("t5_err", {31'd0, err_timeout}, 32'd1);
        chk("t5_mem_req", {31'd0, mem_req}, 32'd0);
        step();
        dm_req = 0;
        step();
        dm_req = 1; dm_we = 1; dm_addr = 32'h34; dm_wdata = 32'h1;
        step();
        mem_ack = 1;
        step();
        chk("t5_err_sticky", {31'd0, err_timeout}, 32'd1);
        chk("t5_store_keeps_rdata", dm_rdata, 32'hDEAD_BEEF);
        mem_ack = 0;
        step();
        dm_req = 0; dm_we = 0;
        step();

        // Reset during a fetch grant
        if_req = 1; if_addr = 32'hC0;
        step();
        chk("t6_granted", {31'd0, mem_req}, 32'd1);
        #1 reset = 0;
        #1;
        chk("t6_async_mem_req", {31'd0, mem_req}, 32'd0);
        chk("t6_mem_addr", mem_addr, 32'd0);
        chk("t6_err", {31'd0, err_timeout}, 32'd0);
        chk("t6_if_rdata", if_rdata, 32'd0);
        chk("t6_dm_rdata", dm_rdata, 32'd0);
        step(); step();
        reset = 1;
        step();
        chk("t6_refetch_addr", mem_addr, 32'hC0);
        mem_ack = 1; mem_rdata = 32'h9999_0000;
        step();
        chk("t6_refetch_rdata", if_rdata, 32'h9999_0000);
        mem_ack = 0;
        step();
        if_req = 0;
        step();

        // Saturation of the conflict counter
        force dut.conflict_cnt_q = 16'hFFFE;
        preset_conf = 1;
        #1 release dut.conflict_cnt_q;
        step();
        preset_conf = 0;
        chk("t7_preset", {16'd0, conflict_cnt}, 32'h0000_FFFE);
        for (int i = 0; i < 3; i++) begin
            if_req = 1; if_addr = 32'h100;
            dm_req = 1; dm_we = 1; dm_addr = 32'h50 + i; dm_wdata = i;
            step();
            chk("t7_saturate", {16'd0, conflict_cnt}, 32'h0000_FFFF);
            mem_ack = 1;
            step();
            mem_ack = 0;
            step();
            dm_req = 0; if_req = 0; dm_we = 0;
            step();
        end
        step(); step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
